// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared opcodes, func3 encodings, FSM states and error codes
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Major opcodes handled by the LSU
   localparam logic [6:0] c_op_l = 7'b0000011;
   localparam logic [6:0] c_op_s = 7'b0100011;

   // func3 encodings (stores reuse the B/H/W codes)
   localparam logic [2:0] c_f3_b  = 3'b000;
   localparam logic [2:0] c_f3_h  = 3'b001;
   localparam logic [2:0] c_f3_w  = 3'b010;
   localparam logic [2:0] c_f3_bu = 3'b100;
   localparam logic [2:0] c_f3_hu = 3'b101;

   // err_code values
   localparam logic [1:0] c_err_none    = 2'd0;
   localparam logic [1:0] c_err_align   = 2'd1;
   localparam logic [1:0] c_err_timeout = 2'd2;

   typedef enum logic [1:0] {
      c_st_idle = 2'd0,
      c_st_req  = 2'd1,
      c_st_wait = 2'd2,
      c_st_done = 2'd3
   } lsu_state_t;

   // True when func3 names a width that exists for the given access type
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      if (is_store)
         ok = (f3 == c_f3_b) || (f3 == c_f3_h) || (f3 == c_f3_w);
      else
         ok = (f3 == c_f3_b) || (f3 == c_f3_h) || (f3 == c_f3_w) ||
              (f3 == c_f3_bu) || (f3 == c_f3_hu);
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane steering: store byte enables and data
//               replication, load shift/extension and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misaligned
);

   logic [31:0] w_shifted;

   // Store lanes and alignment follow the access width in func3[1:0]
   always_comb begin
      be         = 4'b0000;
      wdata      = 32'h0;
      misaligned = 1'b0;
      case (func3[1:0])
         2'b00: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{rs2[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << addr_lo;
            wdata      = {2{rs2[15:0]}};
            misaligned = addr_lo[0];
         end
         2'b10: begin
            be         = 4'b1111;
            wdata      = rs2;
            misaligned = |addr_lo;
         end
         default: ;
      endcase
   end

   // Load data: bring the addressed byte/half to bit 0, then extend
   always_comb begin
      w_shifted = rdata >> {addr_lo, 3'b000};
      case (func3)
         c_f3_b:  ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
         c_f3_h:  ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
         c_f3_bu: ldata = {24'h0, w_shifted[7:0]};
         c_f3_hu: ldata = {16'h0, w_shifted[15:0]};
         default: ldata = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit. Accepts one OP_L/OP_S instruction at a time,
//               runs a req/gnt/rvalid transaction on the data-memory port and
//               returns extended load data or an error with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [31:0] alu_out,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_idx,
   input  logic        flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        err,
   output logic [1:0]  err_code
);

   // Last counter value before the timeout fires (counter starts at 0)
   localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_t  r_state;
   logic        r_in_ready;
   logic        r_is_store;
   logic [2:0]  r_func3;
   logic [1:0]  r_addr_lo;
   logic [4:0]  r_rd_idx;
   logic [15:0] r_cnt;
   logic        r_kill;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_be;
   logic [31:0] r_mem_wdata;
   logic        r_done;
   logic        r_rd_we;
   logic [31:0] r_rd_data;
   logic        r_err;
   logic [1:0]  r_err_code;

   logic        w_idle;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_accept;
   logic        w_bad;
   logic        w_kill_wait;
   logic [2:0]  w_sel_f3;
   logic [1:0]  w_sel_lo;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;
   logic        w_misaligned;

   // In IDLE the aligner looks at the incoming instruction, afterwards at
   // the captured one (needed for load extension in WAIT)
   assign w_idle      = (r_state == c_st_idle);
   assign w_sel_f3    = w_idle ? func3 : r_func3;
   assign w_sel_lo    = w_idle ? alu_out[1:0] : r_addr_lo;
   assign w_is_load   = (opcode == c_op_l);
   assign w_is_store  = (opcode == c_op_s);
   assign w_accept    = in_valid && r_in_ready && !flush && (w_is_load || w_is_store);
   assign w_bad       = w_misaligned || !f3_legal(w_is_store, func3);
   assign w_kill_wait = r_kill || flush;

   lsu_align u_align (
      .func3      (w_sel_f3),
      .addr_lo    (w_sel_lo),
      .rs2        (rs2_data),
      .rdata      (mem_rdata),
      .be         (w_be),
      .wdata      (w_wdata),
      .ldata      (w_ldata),
      .misaligned (w_misaligned)
   );

   // Transaction FSM with registered outputs, capture registers and timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_st_idle;
         r_in_ready  <= 1'b1;
         r_is_store  <= 1'b0;
         r_func3     <= 3'b000;
         r_addr_lo   <= 2'b00;
         r_rd_idx    <= 5'd0;
         r_cnt       <= 16'd0;
         r_kill      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'h0;
         r_mem_be    <= 4'b0000;
         r_mem_wdata <= 32'h0;
         r_done      <= 1'b0;
         r_rd_we     <= 1'b0;
         r_rd_data   <= 32'h0;
         r_err       <= 1'b0;
         r_err_code  <= c_err_none;
      end else begin
         r_done  <= 1'b0;
         r_rd_we <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            c_st_idle: begin
               r_kill <= 1'b0;
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_is_store <= w_is_store;
                  r_func3    <= func3;
                  r_addr_lo  <= alu_out[1:0];
                  r_rd_idx   <= rd_idx;
                  if (w_bad) begin
                     r_state    <= c_st_done;
                     r_done     <= 1'b1;
                     r_err      <= 1'b1;
                     r_err_code <= c_err_align;
                  end else begin
                     r_state     <= c_st_req;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= w_is_store;
                     r_mem_addr  <= {alu_out[31:2], 2'b00};
                     r_mem_be    <= w_is_store ? w_be : 4'b1111;
                     r_mem_wdata <= w_is_store ? w_wdata : 32'h0;
                  end
               end
            end
            c_st_req: begin
               if (mem_gnt || flush) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= 32'h0;
                  r_mem_be    <= 4'b0000;
                  r_mem_wdata <= 32'h0;
               end
               if (mem_gnt) begin
                  // A flush alongside the grant cannot recall the request
                  r_kill <= flush;
                  if (r_is_store) begin
                     r_state    <= c_st_done;
                     r_done     <= 1'b1;
                     r_err_code <= c_err_none;
                  end else begin
                     r_state <= c_st_wait;
                     r_cnt   <= 16'd0;
                  end
               end else if (flush) begin
                  r_state    <= c_st_idle;
                  r_in_ready <= 1'b1;
               end
            end
            c_st_wait: begin
               r_kill <= w_kill_wait;
               if (mem_rvalid) begin
                  r_state    <= c_st_done;
                  r_done     <= 1'b1;
                  r_rd_data  <= w_ldata;
                  r_rd_we    <= !w_kill_wait && (r_rd_idx != 5'd0);
                  r_err_code <= c_err_none;
               end else if (r_cnt == c_tmo_last) begin
                  r_state    <= c_st_done;
                  r_done     <= 1'b1;
                  r_err      <= !w_kill_wait;
                  r_err_code <= w_kill_wait ? c_err_none : c_err_timeout;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            c_st_done: begin
               r_state    <= c_st_idle;
               r_in_ready <= 1'b1;
            end
            default: begin
               r_state    <= c_st_idle;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign done      = r_done;
   // A flush during the DONE cycle itself still suppresses the writeback
   assign rd_we     = r_rd_we && !flush;
   assign err       = r_err && !flush;
   assign rd_addr   = r_rd_idx;
   assign rd_data   = r_rd_data;
   assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [31:0] alu_out;
   logic [31:0] rs2_data;
   logic [4:0]  rd_idx;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        done;
   logic        rd_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        err;
   logic [1:0]  err_code;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [6:0] OPL = 7'b0000011;
   localparam logic [6:0] OPS = 7'b0100011;

   logic [2:0]  t_f3   [0:5];
   logic [31:0] t_addr [0:5];
   logic [4:0]  t_rd   [0:5];
   logic [31:0] t_exp  [0:5];
   logic        t_we   [0:5];

   lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .func3      (func3),
      .alu_out    (alu_out),
      .rs2_data   (rs2_data),
      .rd_idx     (rd_idx),
      .flush      (flush),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .done       (done),
      .rd_we      (rd_we),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   // Presents one instruction for one cycle; returns at the next negedge (T+1)
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd);
      opcode = op; func3 = f3; alu_out = a; rs2_data = d; rd_idx = rd; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_total++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'h0) $display("FAIL reset_mem: got req=%b addr=%h be=%b", mem_req, mem_addr, mem_be); else n_pass++;
      n_total++; if ({done, rd_we, err, err_code, rd_addr, rd_data} !== 42'h0) $display("FAIL reset_out: got done=%b rd_we=%b err=%b code=%0d rd_data=%h want 0", done, rd_we, err, err_code, rd_data); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_sw();
      issue(OPS, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1);
      n_total++; if ({mem_req, mem_we, mem_be} !== 6'b11_1111) $display("FAIL sw_req: got req=%b we=%b be=%b want 1 1 1111", mem_req, mem_we, mem_be); else n_pass++;
      n_total++; if (mem_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", mem_addr); else n_pass++;
      n_total++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); else n_pass++;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      n_total++; if ({done, rd_we, err, in_ready} !== 4'b1000) $display("FAIL sw_done: got done=%b rd_we=%b err=%b in_ready=%b want 1 0 0 0", done, rd_we, err, in_ready); else n_pass++;
      @(negedge clk);
      n_total++; if ({done, in_ready, mem_req} !== 3'b010) $display("FAIL sw_after: got done=%b in_ready=%b req=%b want 0 1 0", done, in_ready, mem_req); else n_pass++;
   endtask

   task automatic test_store_lanes();
      issue(OPS, 3'b001, 32'h102, 32'h1234ABCD, 5'd0);
      n_total++; if ({mem_be, mem_wdata, mem_addr} !== {4'b1100, 32'hABCDABCD, 32'h100}) $display("FAIL sh_lanes: got be=%b wdata=%h addr=%h want 1100 abcdabcd 00000100", mem_be, mem_wdata, mem_addr); else n_pass++;
      @(negedge clk);
      n_total++; if ({mem_req, mem_be, mem_wdata} !== {1'b1, 4'b1100, 32'hABCDABCD} || done !== 1'b0) $display("FAIL sh_hold: got req=%b be=%b wdata=%h done=%b", mem_req, mem_be, mem_wdata, done); else n_pass++;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      n_total++; if ({done, rd_we} !== 2'b10) $display("FAIL sh_done: got done=%b rd_we=%b want 1 0", done, rd_we); else n_pass++;
      @(negedge clk);
      issue(OPS, 3'b000, 32'h101, 32'h0000005A, 5'd0);
      n_total++; if ({mem_be, mem_wdata} !== {4'b0010, 32'h5A5A5A5A}) $display("FAIL sb_lanes: got be=%b wdata=%h want 0010 5a5a5a5a", mem_be, mem_wdata); else n_pass++;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loads();
      t_f3   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
      t_addr = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101};
      t_rd   = '{5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0};
      t_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h80112233, 32'h00000022};
      t_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(OPL, t_f3[i], t_addr[i], 32'hFFFFFFFF, t_rd[i]);
         n_total++; if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'b1111, 32'h100}) $display("FAIL ld%0d_req: got req=%b we=%b be=%b addr=%h", i, mem_req, mem_we, mem_be, mem_addr); else n_pass++;
         mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80112233;
         @(negedge clk);
         mem_rvalid = 1'b0;
         n_total++; if ({done, rd_we, err} !== {1'b1, t_we[i], 1'b0}) $display("FAIL ld%0d_done: got done=%b rd_we=%b err=%b want 1 %b 0", i, done, rd_we, err, t_we[i]); else n_pass++;
         n_total++; if (rd_data !== t_exp[i] || rd_addr !== t_rd[i]) $display("FAIL ld%0d_data: got %h rd=%0d want %h rd=%0d", i, rd_data, rd_addr, t_exp[i], t_rd[i]); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_misaligned();
      issue(OPL, 3'b010, 32'h101, 32'h0, 5'd4);
      n_total++; if ({done, err, err_code, rd_we, mem_req} !== 6'b11_01_0_0) $display("FAIL lw_misalign: got done=%b err=%b code=%0d rd_we=%b req=%b want 1 1 1 0 0", done, err, err_code, rd_we, mem_req); else n_pass++;
      @(negedge clk);
      n_total++; if ({mem_req, done, in_ready} !== 3'b001) $display("FAIL lw_misalign_after: got req=%b done=%b in_ready=%b", mem_req, done, in_ready); else n_pass++;
      issue(OPS, 3'b011, 32'h100, 32'h0, 5'd0);
      n_total++; if ({done, err, err_code, mem_req} !== 5'b11_01_0) $display("FAIL st_illegal: got done=%b err=%b code=%0d req=%b want 1 1 1 0", done, err, err_code, mem_req); else n_pass++;
      @(negedge clk);
      issue(7'b0110011, 3'b000, 32'h100, 32'h0, 5'd1);
      n_total++; if ({in_ready, mem_req, done} !== 3'b100) $display("FAIL ignored_op: got in_ready=%b req=%b done=%b want 1 0 0", in_ready, mem_req, done); else n_pass++;
   endtask

   task automatic test_timeout();
      issue(OPL, 3'b010, 32'h200, 32'h0, 5'd2);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_total++; if (done !== 1'b0) $display("FAIL tmo_wait%0d: got done=%b want 0", k, done); else n_pass++;
         @(negedge clk);
      end
      n_total++; if ({done, err, err_code, rd_we} !== 5'b11_10_0) $display("FAIL tmo_done: got done=%b err=%b code=%0d rd_we=%b want 1 1 2 0", done, err, err_code, rd_we); else n_pass++;
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      n_total++; if ({done, in_ready} !== 2'b01) $display("FAIL tmo_late_rvalid: got done=%b in_ready=%b want 0 1", done, in_ready); else n_pass++;
      @(negedge clk);
      mem_rvalid = 1'b0;
      n_total++; if ({done, err_code} !== 3'b0_10) $display("FAIL tmo_hold: got done=%b code=%0d want 0 2", done, err_code); else n_pass++;
   endtask

   task automatic test_flush();
      flush = 1'b1;
      issue(OPS, 3'b010, 32'h100, 32'h1, 5'd0);
      flush = 1'b0;
      n_total++; if ({in_ready, mem_req} !== 2'b10) $display("FAIL flush_idle: got in_ready=%b req=%b want 1 0", in_ready, mem_req); else n_pass++;
      issue(OPS, 3'b010, 32'h100, 32'h1, 5'd0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_total++; if ({mem_req, done, in_ready} !== 3'b001) $display("FAIL flush_req: got req=%b done=%b in_ready=%b want 0 0 1", mem_req, done, in_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (done !== 1'b0) $display("FAIL flush_req_nodone: got done=%b want 0", done); else n_pass++;
      issue(OPL, 3'b010, 32'h100, 32'h0, 5'd3);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      @(negedge clk);
      mem_rvalid = 1'b0;
      n_total++; if ({done, rd_we, err} !== 3'b100) $display("FAIL flush_wait: got done=%b rd_we=%b err=%b want 1 0 0", done, rd_we, err); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      issue(OPS, 3'b010, 32'h100, 32'h1, 5'd0);
      rst = 1'b1;
      #1;
      n_total++; if ({mem_req, in_ready} !== 2'b01) $display("FAIL rst_req: got req=%b in_ready=%b want 0 1", mem_req, in_ready); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(OPL, 3'b010, 32'h100, 32'h0, 5'd6);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      n_total++; if ({in_ready, mem_req, done, rd_we, err, err_code} !== 7'b1_0_0_0_0_00) $display("FAIL rst_wait: got in_ready=%b req=%b done=%b rd_we=%b err=%b code=%0d", in_ready, mem_req, done, rd_we, err, err_code); else n_pass++;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_rvalid = 1'b0;
      n_total++; if ({done, rd_we, rd_data} !== 34'h0) $display("FAIL rst_rvalid: got done=%b rd_we=%b rd_data=%h want 0 0 0", done, rd_we, rd_data); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; opcode = 7'h0; func3 = 3'h0; alu_out = 32'h0;
      rs2_data = 32'h0; rd_idx = 5'd0; flush = 1'b0; mem_gnt = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      test_reset();
      test_store_sw();
      test_store_lanes();
      test_loads();
      test_misaligned();
      test_timeout();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the integer ALU in the RV32I core.
- Consumes the ALU's address result for OP_L/OP_S instructions plus the store data.
- Issues a single request/grant/response transaction on the data-memory port.
- Returns aligned, sign/zero-extended load data with a register-file write strobe, or an error.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT for mem_rvalid before aborting with a timeout error (1..65535).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ALU result valid, instruction presented
- in_ready  out  1  high only in IDLE; instruction accepted when in_valid && in_ready
- opcode  in  7  instruction opcode (OP_L=0000011, OP_S=0100011)
- func3  in  3  width/sign selector
- alu_out  in  32  effective address from ALU
- rs2_data  in  32  store data
- rd_idx  in  5  load destination register
- flush  in  1  pipeline kill
- mem_req  out  1  request, held until mem_gnt
- mem_we  out  1  1=store
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word
- done  out  1  one-cycle completion pulse
- rd_we  out  1  register write strobe, coincident with done
- rd_addr  out  5  destination register
- rd_data  out  32  extended load result
- err  out  1  error flag, coincident with done
- err_code  out  2  0=none, 1=misaligned/illegal func3, 2=timeout

Behaviour:
- Reset (async, immediate): state IDLE; every output 0 except in_ready=1; timeout counter 0; kill flag 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, accept:
  - Capture opcode/func3/address/rs2/rd_idx.
  - Opcodes other than OP_L/OP_S are ignored: no state change, no done.
- Alignment check at accept:
  - LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - func3 not in {LB,LH,LW,LBU,LHU} for loads, or not in {SB,SH,SW} for stores: illegal.
  - Misaligned or illegal: go to DONE with err=1, err_code=1, rd_we=0, no mem_req.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata stable until the mem_gnt cycle.
  - Store on gnt: go to DONE.
  - Load on gnt: go to WAIT, clear the counter.
- Store lanes:
  - SB: be=0001<<a[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<a[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
  - Loads drive be=1111.
- WAIT:
  - mem_rvalid is sampled from the cycle after gnt onward; rvalid in IDLE/REQ is ignored.
  - On rvalid: register rd_data = (rdata>>8*a[1:0]) extended per func3 (LB/LH sign, LBU/LHU zero, LW full), then go to DONE.
  - Counter increments each WAIT cycle without rvalid; reaching TIMEOUT_CYCLES goes to DONE with err=1, err_code=2, rd_we=0.
- DONE:
  - done=1 for exactly one cycle.
  - rd_we=1 only for an error-free, non-killed load with rd_idx≠0.
  - Store: done with rd_we=0.
  - Next state IDLE; in_ready rises the following cycle.
- Latency, zero wait states:
  - Store: accept T, REQ+gnt T+1, done T+2.
  - Load: rvalid T+2, done T+3.
- flush:
  - IDLE: blocks acceptance that cycle.
  - REQ without gnt: drop request, go to IDLE, no done.
  - REQ with simultaneous gnt, WAIT, or DONE: transaction completes; kill flag forces rd_we=0 and err=0, done still pulses.
- rd_data, err_code hold their values until the next DONE.
- Reset mid-transaction: mem_req drops asynchronously; a later rvalid is ignored.

Decomposition:
- Shared package lsu_pkg: OP_L/OP_S opcodes, load/store func3 constants, state enum, err_code constants.
- Sub-module lsu_align (combinational): inputs func3, addr[1:0], rs2, rdata; outputs be, wdata, extended load data, misaligned flag.
- lsu holds the FSM, capture registers, timeout counter and kill flag.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, gnt immediate -> T+1 mem_req/we=1, addr 0x100, be 1111, wdata 0xDEADBEEF; T+2 done=1, rd_we=0.
- LB addr 0x103, rdata 0x80112233 -> rd_data 0xFFFFFF80, rd_we=1; LBU same -> 0x00000080.
- SH addr 0x102, rs2 0x1234ABCD -> be 1100, wdata 0xABCDABCD, mem_addr 0x100.
- LW addr 0x101 -> no mem_req ever; done at T+1 with err=1, err_code=1, rd_we=0.
- LW, TIMEOUT_CYCLES=4, rvalid never -> 4 WAIT cycles, then done with err_code=2; rvalid injected afterwards is ignored.
- Flush in REQ with gnt=0 -> mem_req drops next cycle, no done. Assert rst during WAIT -> outputs 0 immediately, in_ready=1.
